// File: rtl/register_file.sv
// Multi-port register file: two combinational read ports and one synchronous write port.
// Register 0 is hard-wired to zero and a synchronous reset clears every entry.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] R_Addr_A,
  input  logic [ADDR_WIDTH-1:0] R_Addr_B,
  input  logic [ADDR_WIDTH-1:0] W_Addr,
  input  logic                  Write_Reg,
  input  logic [DATA_WIDTH-1:0] W_Data,
  output logic [DATA_WIDTH-1:0] R_Data_A,
  output logic [DATA_WIDTH-1:0] R_Data_B
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  // Power-up contents are zero so reads before the first reset are defined
  logic [DATA_WIDTH-1:0] r_regs [NREGS] = '{default: '0};

  logic w_wr_en;
  assign w_wr_en = Write_Reg && (W_Addr != '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[W_Addr] <= W_Data;
    end
  end

  // No bypass: a same-cycle write becomes visible only after the edge
  assign R_Data_A = (R_Addr_A == '0) ? '0 : r_regs[R_Addr_A];
  assign R_Data_B = (R_Addr_B == '0) ? '0 : r_regs[R_Addr_B];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file with hand-computed expectations.
module tb_register_file;

  logic        Clk;
  logic        Reset;
  logic [4:0]  R_Addr_A;
  logic [4:0]  R_Addr_B;
  logic [4:0]  W_Addr;
  logic        Write_Reg;
  logic [31:0] W_Data;
  logic [31:0] R_Data_A;
  logic [31:0] R_Data_B;

  int checks = 0;
  int errors = 0;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .R_Addr_A (R_Addr_A),
    .R_Addr_B (R_Addr_B),
    .W_Addr   (W_Addr),
    .Write_Reg(Write_Reg),
    .W_Data   (W_Data),
    .R_Data_A (R_Data_A),
    .R_Data_B (R_Data_B)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [4:0] b,
                    input logic [31:0] ea, input logic [31:0] eb);
    R_Addr_A = a;
    R_Addr_B = b;
    #1;
    check({tag, "_A"}, R_Data_A, ea);
    check({tag, "_B"}, R_Data_B, eb);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    W_Addr    = addr;
    W_Data    = data;
    Write_Reg = 1'b1;
    tick();
    Write_Reg = 1'b0;
  endtask

  initial begin
    Reset     = 1'b0;
    R_Addr_A  = '0;
    R_Addr_B  = '0;
    W_Addr    = '0;
    Write_Reg = 1'b0;
    W_Data    = '0;

    // Contents before any reset
    #1;
    rd("preinit", 5'd1, 5'd31, 32'h0, 32'h0);

    // Reset, then every address reads zero on both ports
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd($sformatf("reset_addr%0d", i), 5'(i), 5'(31 - i), 32'h0, 32'h0);
    end

    // Basic write/read
    tick();
    wr(5'd1, 32'h1111_1111);
    wr(5'd2, 32'h2222_2222);
    rd("basic", 5'd1, 5'd2, 32'h1111_1111, 32'h2222_2222);

    // Highest address and all-ones data
    tick();
    wr(5'd31, 32'hFFFF_FFFF);
    wr(5'd30, 32'h8000_0001);
    rd("top_addr", 5'd31, 5'd30, 32'hFFFF_FFFF, 32'h8000_0001);

    // Write disabled
    tick();
    W_Addr = 5'd1; W_Data = 32'hDEAD_BEEF; Write_Reg = 1'b0;
    tick();
    rd("wr_disabled", 5'd1, 5'd2, 32'h1111_1111, 32'h2222_2222);

    // Register 0 ignores writes
    tick();
    wr(5'd0, 32'hFFFF_FFFF);
    rd("reg0", 5'd0, 5'd1, 32'h0, 32'h1111_1111);

    // Enable pulse that goes away before the edge must not write
    tick();
    W_Addr = 5'd6; W_Data = 32'h6666_6666; Write_Reg = 1'b1;
    #2;
    Write_Reg = 1'b0; W_Addr = 5'd7;
    tick();
    rd("glitch", 5'd6, 5'd7, 32'h0, 32'h0);

    // Overwrite keeps only the latest value
    tick();
    wr(5'd2, 32'hA5A5_5A5A);
    rd("overwrite", 5'd2, 5'd1, 32'hA5A5_5A5A, 32'h1111_1111);
    tick();
    wr(5'd2, 32'h2222_2222);

    // Reset asserted while Clk is low has no effect until the rising edge
    @(negedge Clk);
    #1;
    Reset = 1'b1;
    rd("sync_rst_hold", 5'd1, 5'd2, 32'h1111_1111, 32'h2222_2222);
    tick();
    rd("sync_rst_edge", 5'd1, 5'd2, 32'h0, 32'h0);
    rd("sync_rst_top", 5'd31, 5'd30, 32'h0, 32'h0);
    Reset = 1'b0;

    // Reset wins over a simultaneous write
    tick();
    wr(5'd3, 32'hABCD_0123);
    rd("pre_prio", 5'd3, 5'd3, 32'hABCD_0123, 32'hABCD_0123);
    tick();
    Reset = 1'b1; W_Addr = 5'd3; W_Data = 32'h3333_3333; Write_Reg = 1'b1;
    tick();
    Reset = 1'b0; Write_Reg = 1'b0;
    rd("rst_priority", 5'd3, 5'd3, 32'h0, 32'h0);

    // No write-to-read bypass
    @(negedge Clk);
    #1;
    W_Addr = 5'd4; W_Data = 32'h4444_4444; Write_Reg = 1'b1;
    rd("bypass_before", 5'd4, 5'd4, 32'h0, 32'h0);
    tick();
    Write_Reg = 1'b0;
    rd("bypass_after", 5'd4, 5'd4, 32'h4444_4444, 32'h4444_4444);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
